// File: rtl/clock_drive_generation_pkg.sv
// ---------------------------------------------------------------------------
// clks_alot_p : shared types for the clock drive generator.
//
//   COUNTER_WIDTH        width of every half-rate count (half period - 1)
//   half_rate_limits_s   band limits, same encoding as the sense side.
//                        maximum_band_minus_one is the SHORTEST half period
//                        allowed (highest frequency), minimum_band_minus_one
//                        the LONGEST.
//   drive_state_e        generator FSM states
// ---------------------------------------------------------------------------
package clks_alot_p;

   localparam int COUNTER_WIDTH = 8;

   typedef struct packed {
      logic [COUNTER_WIDTH-1:0] maximum_band_minus_one;
      logic [COUNTER_WIDTH-1:0] minimum_band_minus_one;
   } half_rate_limits_s;

   typedef enum logic [1:0] {
      DRIVE_IDLE     = 2'd0,
      DRIVE_RUNNING  = 2'd1,
      DRIVE_STOPPING = 2'd2
   } drive_state_e;

endpackage

// File: rtl/clock_drive_generation_rate_latch.sv
// ---------------------------------------------------------------------------
// drive_rate_latch : half-rate request handshake and pending register.
//
// Handshake: rate_ready_o is high in any cycle where rate_valid_i is high and
// no request is pending; that cycle is the transfer. An accepted value is
// held in the pending register until the generator consumes it (consume_i),
// which only happens at a half-period boundary or while idle.
//
// Optional limit check (macro CLKS_ALOT_DRIVE_LIMIT_CHECK_EN): a request
// outside [maximum_band_minus_one, minimum_band_minus_one] still completes the
// handshake but raises rate_reject_o in that cycle and is discarded. Without
// the macro every request is stored and rate_reject_o is tied low.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   limits_i             band limits
//   rate_valid_i         request valid
//   rate_minus_one_i     requested half period minus one
//   consume_i            generator takes the pending value this cycle
//   rate_ready_o         request transferred this cycle
//   rate_reject_o        transferred request refused as out of band
//   pending_valid_o      a value is waiting to become active
//   pending_rate_o       the waiting value
// ---------------------------------------------------------------------------
module drive_rate_latch #(
   parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  clks_alot_p::half_rate_limits_s   limits_i,
   input  logic                             rate_valid_i,
   input  logic [COUNTER_WIDTH-1:0]         rate_minus_one_i,
   input  logic                             consume_i,
   output logic                             rate_ready_o,
   output logic                             rate_reject_o,
   output logic                             pending_valid_o,
   output logic [COUNTER_WIDTH-1:0]         pending_rate_o
);

   logic                     pending_valid_q, pending_valid_d;
   logic [COUNTER_WIDTH-1:0] pending_rate_q, pending_rate_d;

   assign rate_ready_o = rate_valid_i && !pending_valid_q;

`ifdef CLKS_ALOT_DRIVE_LIMIT_CHECK_EN
   logic out_of_band;
   assign out_of_band   = (rate_minus_one_i < limits_i.maximum_band_minus_one) ||
                          (rate_minus_one_i > limits_i.minimum_band_minus_one);
   assign rate_reject_o = rate_ready_o && out_of_band;
`else
   logic unused_limits;
   assign unused_limits = ^limits_i;
   assign rate_reject_o = 1'b0;
`endif

   always_comb begin
      pending_valid_d = pending_valid_q;
      pending_rate_d  = pending_rate_q;
      // consume and accept are exclusive: consume needs a pending value,
      // accept needs none.
      if (consume_i) begin
         pending_valid_d = 1'b0;
      end
      if (rate_ready_o && !rate_reject_o) begin
         pending_valid_d = 1'b1;
         pending_rate_d  = rate_minus_one_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pending_valid_q <= 1'b0;
         pending_rate_q  <= '0;
      end else begin
         pending_valid_q <= pending_valid_d;
         pending_rate_q  <= pending_rate_d;
      end
   end

   assign pending_valid_o = pending_valid_q;
   assign pending_rate_o  = pending_rate_q;

endmodule

// File: rtl/clock_drive_generation.sv
// ---------------------------------------------------------------------------
// clock_drive_generation : programmable divided clock generator.
//
// drive_clk_o toggles every (active_rate_minus_one + 1) clk_i cycles while
// running. New rates arrive through a valid/ready handshake (see
// drive_rate_latch) and only take effect at a half-period boundary, so no
// half period is ever shortened or stretched mid-way. Stopping lets the
// half period in progress finish and parks the clock at IDLE_LEVEL.
//
// Optional feature: define CLKS_ALOT_DRIVE_LIMIT_CHECK_EN to reject requests
// outside the band given by half_rate_limits_i.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   half_rate_limits_i        band limits; maximum_band_minus_one is also the
//                             rate loaded by reset
//   enable_i                  level, high = run, low = stop
//   rate_valid_i / rate_minus_one_i / rate_ready_o / rate_reject_o
//                             rate request handshake
//   drive_clk_o               generated clock
//   rise_event_o/fall_event_o one-cycle pulses aligned with drive_clk_o edges
//   current_rate_counter_o    cycles elapsed in the current half period
//   busy_o                    RUNNING or STOPPING
//   debug_state_o             FSM state (drive_state_e encoding)
// ---------------------------------------------------------------------------
module clock_drive_generation #(
   parameter int   COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
   parameter logic IDLE_LEVEL    = 1'b0
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  clks_alot_p::half_rate_limits_s   half_rate_limits_i,
   input  logic                             enable_i,
   input  logic                             rate_valid_i,
   input  logic [COUNTER_WIDTH-1:0]         rate_minus_one_i,
   output logic                             rate_ready_o,
   output logic                             rate_reject_o,
   output logic                             drive_clk_o,
   output logic                             rise_event_o,
   output logic                             fall_event_o,
   output logic [COUNTER_WIDTH-1:0]         current_rate_counter_o,
   output logic                             busy_o,
   output logic [1:0]                       debug_state_o
);

   import clks_alot_p::*;

   drive_state_e             state_q, state_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic [COUNTER_WIDTH-1:0] active_q, active_d;
   logic                     drive_q, drive_d;
   logic                     rise_q, rise_d;
   logic                     fall_q, fall_d;

   logic                     busy;
   logic                     boundary;
   logic                     consume;
   logic                     pending_valid;
   logic [COUNTER_WIDTH-1:0] pending_rate;

   drive_rate_latch #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_rate_latch (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .limits_i         (half_rate_limits_i),
      .rate_valid_i     (rate_valid_i),
      .rate_minus_one_i (rate_minus_one_i),
      .consume_i        (consume),
      .rate_ready_o     (rate_ready_o),
      .rate_reject_o    (rate_reject_o),
      .pending_valid_o  (pending_valid),
      .pending_rate_o   (pending_rate)
   );

   assign busy = (state_q != DRIVE_IDLE);

   // The all-ones check keeps the counter from wrapping even if the active
   // rate were somehow larger than the counter can hold.
   assign boundary = busy && ((count_q == active_q) ||
                              (count_q == {COUNTER_WIDTH{1'b1}}));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      active_d = active_q;
      drive_d  = drive_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      consume  = 1'b0;

      case (state_q)
         DRIVE_IDLE: begin
            count_d = '0;
            drive_d = IDLE_LEVEL;
            // Load any pending rate before starting so the first half
            // period already uses it.
            if (pending_valid) begin
               active_d = pending_rate;
               consume  = 1'b1;
            end else if (enable_i) begin
               state_d = DRIVE_RUNNING;
            end
         end

         default: begin
            if (boundary && pending_valid) begin
               active_d = pending_rate;
               consume  = 1'b1;
            end

            // Leave STOPPING once the clock sits at IDLE_LEVEL having just
            // got there at a boundary: either this cycle is a boundary, or
            // the previous boundary produced the edge that reached it. The
            // extra cycle keeps rise/fall pulses out of IDLE.
            if ((state_q == DRIVE_STOPPING) && !enable_i &&
                (drive_q == IDLE_LEVEL) && (boundary || rise_q || fall_q)) begin
               state_d = DRIVE_IDLE;
               count_d = '0;
            end else begin
               if (boundary) begin
                  count_d = '0;
                  // While stopping, never toggle away from IDLE_LEVEL.
                  if ((state_q == DRIVE_RUNNING) || enable_i ||
                      (drive_q != IDLE_LEVEL)) begin
                     drive_d = ~drive_q;
                     rise_d  = ~drive_q;
                     fall_d  = drive_q;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end

               if ((state_q == DRIVE_RUNNING) && !enable_i) begin
                  state_d = DRIVE_STOPPING;
               end else if ((state_q == DRIVE_STOPPING) && enable_i) begin
                  state_d = DRIVE_RUNNING;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= DRIVE_IDLE;
         count_q  <= '0;
         active_q <= half_rate_limits_i.maximum_band_minus_one;
         drive_q  <= IDLE_LEVEL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         active_q <= active_d;
         drive_q  <= drive_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign drive_clk_o            = drive_q;
   assign rise_event_o           = rise_q;
   assign fall_event_o           = fall_q;
   assign current_rate_counter_o = count_q;
   assign busy_o                 = busy;
   assign debug_state_o          = state_q;

endmodule

// File: tb/tb_clock_drive_generation.sv
// ---------------------------------------------------------------------------
// Bench for clock_drive_generation. A cycle-level model describes the
// generated clock in terms of absolute cycle numbers (start of the current
// half period, its length) plus a queue holding the pending rate; every
// output is compared against it on each falling edge. Directed phases add
// literal timing expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_clock_drive_generation;
   import clks_alot_p::*;

   localparam int W = clks_alot_p::COUNTER_WIDTH;
`ifdef CLKS_ALOT_DRIVE_LIMIT_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;

   // ---------------- clock / reset / DUT ----------------
   logic              clk;
   logic              reset_i;
   half_rate_limits_s limits;
   logic              enable_i;
   logic              rate_valid_i;
   logic [W-1:0]      rate_minus_one_i;
   logic              rate_ready_o;
   logic              rate_reject_o;
   logic              drive_clk_o;
   logic              rise_event_o;
   logic              fall_event_o;
   logic [W-1:0]      current_rate_counter_o;
   logic              busy_o;
   logic [1:0]        debug_state_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   clock_drive_generation dut (
      .clk_i                  (clk),
      .reset_i                (reset_i),
      .half_rate_limits_i     (limits),
      .enable_i               (enable_i),
      .rate_valid_i           (rate_valid_i),
      .rate_minus_one_i       (rate_minus_one_i),
      .rate_ready_o           (rate_ready_o),
      .rate_reject_o          (rate_reject_o),
      .drive_clk_o            (drive_clk_o),
      .rise_event_o           (rise_event_o),
      .fall_event_o           (fall_event_o),
      .current_rate_counter_o (current_rate_counter_o),
      .busy_o                 (busy_o),
      .debug_state_o          (debug_state_o)
   );

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int           cyc = 0;
   bit           model_ok = 1'b0;
   int           m_mode;
   int           m_start;     // cycle number at which the current half began
   int           m_active;    // half period minus one in force
   bit           m_level, m_rise, m_fall;
   logic [W-1:0] exp_q[$];    // pending rate (at most one)
   int           rise_cyc[$];
   int           fall_cyc[$];

   function automatic bit out_of_band(input logic [W-1:0] r);
      return CHECK_EN && ((r < limits.maximum_band_minus_one) ||
                          (r > limits.minimum_band_minus_one));
   endfunction

   always @(posedge clk) begin : model_b
      bit half_done, accept, edge_prev;
      cyc++;
      edge_prev = m_rise | m_fall;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (reset_i) begin
         model_ok = 1'b1;
         m_mode   = M_IDLE;
         m_level  = 1'b0;
         m_start  = cyc;
         m_active = int'(limits.maximum_band_minus_one);
         exp_q.delete();
      end else if (model_ok) begin
         accept = rate_valid_i && (exp_q.size() == 0);
         if (m_mode == M_IDLE) begin
            m_start = cyc;
            m_level = 1'b0;
            if (exp_q.size() != 0) m_active = int'(exp_q.pop_front());
            else if (enable_i) m_mode = M_RUN;
         end else begin
            // a half period is m_active+1 cycles long
            half_done = ((cyc - m_start) == (m_active + 1));
            if (half_done && exp_q.size() != 0) m_active = int'(exp_q.pop_front());
            if (m_mode == M_STOP && !enable_i && m_level == 1'b0 && (half_done || edge_prev)) begin
               m_mode  = M_IDLE;
               m_start = cyc;
            end else begin
               if (half_done) begin
                  m_start = cyc;
                  if (m_mode == M_RUN || enable_i || m_level != 1'b0) begin
                     m_level = !m_level;
                     m_rise  = m_level;
                     m_fall  = !m_level;
                  end
               end
               if (m_mode == M_RUN && !enable_i) m_mode = M_STOP;
               else if (m_mode == M_STOP && enable_i) m_mode = M_RUN;
            end
         end
         if (accept && !out_of_band(rate_minus_one_i)) exp_q.push_back(rate_minus_one_i);
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         if (rise_event_o === 1'b1) rise_cyc.push_back(cyc);
         if (fall_event_o === 1'b1) fall_cyc.push_back(cyc);
         check("drive_clk", drive_clk_o, m_level);
         check("rise_event", rise_event_o, m_rise);
         check("fall_event", fall_event_o, m_fall);
         check("counter", current_rate_counter_o, cyc - m_start);
         check("busy", busy_o, m_mode != M_IDLE);
         check("rate_ready", rate_ready_o, rate_valid_i && (exp_q.size() == 0));
         check("rate_reject", rate_reject_o,
               rate_valid_i && (exp_q.size() == 0) && out_of_band(rate_minus_one_i));
         check("rise_fall_exclusive", rise_event_o & fall_event_o, 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rate(input int r, output logic rdy, output logic rej);
      rate_valid_i     = 1'b1;
      rate_minus_one_i = W'(r);
      #1;
      rdy = rate_ready_o;
      rej = rate_reject_o;
      @(posedge clk);
      #1;
      rate_valid_i = 1'b0;
   endtask

   task automatic wait_edges(input bit want_fall, input int n, input int budget, input string name);
      int k = 0;
      while (((want_fall ? fall_cyc.size() : rise_cyc.size()) < n) && (k < budget)) begin
         cyc_wait(1);
         k++;
      end
      if ((want_fall ? fall_cyc.size() : rise_cyc.size()) < n)
         check({name, "_timeout"}, want_fall ? fall_cyc.size() : rise_cyc.size(), n);
   endtask

   task automatic do_reset(input int n);
      reset_i = 1'b1;
      cyc_wait(n);
      reset_i = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic rdy, rej;
      int   en_cyc, r_edge;
      bit   prev;

      reset_i          = 1'b1;
      enable_i         = 1'b0;
      rate_valid_i     = 1'b0;
      rate_minus_one_i = '0;
      limits.maximum_band_minus_one = W'(0);
      limits.minimum_band_minus_one = W'(200);

      // reset values
      cyc_wait(2);
      check("reset_drive", drive_clk_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_counter", current_rate_counter_o, 0);
      check("reset_pulses", {rise_event_o, fall_event_o}, 0);
      reset_i = 1'b0;

      // rate 3, first rise 4 cycles after enable, period 8, 50% duty
      send_rate(3, rdy, rej);
      check("rate3_ready", rdy, 1);
      cyc_wait(2);
      rise_cyc.delete();
      fall_cyc.delete();
      enable_i = 1'b1;
      en_cyc   = cyc + 1;
      wait_edges(1'b0, 2, 40, "rate3_rises");
      if (rise_cyc.size() >= 2) begin
         check("first_rise_latency", rise_cyc[0] - en_cyc, 4);
         check("rate3_period", rise_cyc[1] - rise_cyc[0], 8);
      end
      if (fall_cyc.size() >= 1 && rise_cyc.size() >= 1)
         check("rate3_high_time", fall_cyc[0] - rise_cyc[0], 4);

      // stop one cycle after a rise: high half completes, then idle low
      r_edge = rise_cyc[rise_cyc.size()-1];
      fall_cyc.delete();
      enable_i = 1'b0;
      wait_edges(1'b1, 1, 20, "stop_fall");
      if (fall_cyc.size() >= 1) check("stop_high_time", fall_cyc[0] - r_edge, 4);
      cyc_wait(2);
      check("stop_busy", busy_o, 0);
      check("stop_drive", drive_clk_o, 0);

      // rate change mid half period: current half stays 4, then halves of 2
      rise_cyc.delete();
      fall_cyc.delete();
      enable_i = 1'b1;
      wait_edges(1'b0, 1, 20, "restart_rise");
      r_edge = (rise_cyc.size() > 0) ? rise_cyc[0] : 0;
      rise_cyc.delete();
      fall_cyc.delete();
      send_rate(1, rdy, rej);
      check("rate1_ready", rdy, 1);
      wait_edges(1'b1, 2, 30, "rate1_falls");
      if (fall_cyc.size() >= 2 && rise_cyc.size() >= 1) begin
         check("change_current_half", fall_cyc[0] - r_edge, 4);
         check("change_next_low", rise_cyc[0] - fall_cyc[0], 2);
         check("change_next_high", fall_cyc[1] - rise_cyc[0], 2);
      end

      // rate 0: divide by two, then reset while high
      send_rate(0, rdy, rej);
      cyc_wait(6);
      prev = drive_clk_o;
      for (int i = 0; i < 4; i++) begin
         cyc_wait(1);
         check("div2_toggle", drive_clk_o, !prev);
         prev = drive_clk_o;
      end
      if (drive_clk_o == 1'b0) cyc_wait(1);
      reset_i = 1'b1;
      cyc_wait(1);
      check("reset_mid_drive", drive_clk_o, 0);
      check("reset_mid_counter", current_rate_counter_o, 0);
      check("reset_mid_busy", busy_o, 0);
      enable_i = 1'b0;

      // band limits 2..10
      limits.maximum_band_minus_one = W'(2);
      limits.minimum_band_minus_one = W'(10);
      do_reset(2);
      send_rate(5, rdy, rej);
      check("band_inband_ready", rdy, 1);
      check("band_inband_reject", rej, 0);
      cyc_wait(2);
      rise_cyc.delete();
      enable_i = 1'b1;
      wait_edges(1'b0, 1, 30, "band_rise");
      send_rate(20, rdy, rej);
      check("band_high_ready", rdy, 1);
`ifdef CLKS_ALOT_DRIVE_LIMIT_CHECK_EN
      check("band_high_reject", rej, 1);
      send_rate(0, rdy, rej);
      check("band_low_ready", rdy, 1);
      check("band_low_reject", rej, 1);
      rise_cyc.delete();
      wait_edges(1'b0, 2, 60, "band_period_rises");
      if (rise_cyc.size() >= 2) check("band_period_kept", rise_cyc[1] - rise_cyc[0], 12);
`else
      check("band_high_reject", rej, 0);
`endif
      enable_i = 1'b0;
      cyc_wait(50);

      // random phase
      limits.maximum_band_minus_one = W'(1);
      limits.minimum_band_minus_one = W'(9);
      do_reset(2);
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 19) == 0) enable_i = !enable_i;
         rate_valid_i     = ($urandom_range(0, 3) == 0);
         rate_minus_one_i = W'($urandom_range(0, 12));
         reset_i          = ($urandom_range(0, 299) == 0);
         cyc_wait(1);
      end
      rate_valid_i = 1'b0;
      reset_i      = 1'b0;
      cyc_wait(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
